// File: rtl/pll_i2c_master.sv
// APB-controlled I2C write engine for the two clock-generator PLL chips.
// Each go command sends START, dev+W, reg, data, STOP on the selected bus.
module pll_i2c_master #(
    parameter int unsigned CPU_FREQ  = 85_661_538,
    parameter int unsigned I2C_FREQ  = 100_000,
    parameter logic [15:0] DIV_RESET = 16'(CPU_FREQ / (4 * I2C_FREQ) - 1)
) (
    input  logic        clk_cpu,
    input  logic        reset,
    input  logic [3:0]  apb_PADDR,
    input  logic        apb_PSEL,
    input  logic        apb_PENABLE,
    output logic        apb_PREADY,
    input  logic        apb_PWRITE,
    input  logic [31:0] apb_PWDATA,
    output logic [31:0] apb_PRDATA,
    output logic        plla_scl_oe,
    output logic        plla_sda_oe,
    input  logic        plla_sda_in,
    output logic        pllb_scl_oe,
    output logic        pllb_sda_oe,
    input  logic        pllb_sda_in,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP} state_t;

    state_t      state;
    logic [1:0]  q;
    logic [2:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic [7:0]  reg_addr;
    logic [7:0]  wr_data;
    logic [6:0]  dev;
    logic        bus_sel;
    logic [15:0] div;
    logic [15:0] cnt;
    logic        nack;
    logic        done;
    logic        ack_level;
    logic        scl_low;
    logic        sda_low;
    logic [1:0]  sync_a;
    logic [1:0]  sync_b;

    logic        access;
    logic        go;
    logic        wr_div;
    logic        tick;
    logic        sda_sel;
    logic [7:0]  cur_byte;
    logic [7:0]  nxt_byte;
    logic        unused_bits;

    function automatic logic [7:0] pick_byte(input logic [1:0] idx, input logic [6:0] d,
                                             input logic [7:0] r, input logic [7:0] w);
        case (idx)
            2'd0:    return {d, 1'b0};
            2'd1:    return r;
            default: return w;
        endcase
    endfunction

    assign access   = apb_PSEL & apb_PENABLE & apb_PWRITE;
    assign go       = access & (apb_PADDR[3:2] == 2'd0) & apb_PWDATA[31] & ~busy;
    assign wr_div   = access & (apb_PADDR[3:2] == 2'd2) & ~busy;
    assign tick     = (cnt == 16'd0);
    assign sda_sel  = bus_sel ? sync_b[1] : sync_a[1];
    assign cur_byte = pick_byte(byte_idx, dev, reg_addr, wr_data);
    assign nxt_byte = pick_byte(byte_idx + 2'd1, dev, reg_addr, wr_data);

    assign apb_PREADY  = 1'b1;
    assign unused_bits = ^{apb_PADDR[1:0], apb_PWDATA[30:25], apb_PWDATA[23]};

    // bus_sel only changes at go while both line drivers are released
    assign plla_scl_oe = scl_low & ~bus_sel;
    assign plla_sda_oe = sda_low & ~bus_sel;
    assign pllb_scl_oe = scl_low & bus_sel;
    assign pllb_sda_oe = sda_low & bus_sel;

    always_comb begin
        apb_PRDATA = 32'd0;
        case (apb_PADDR[3:2])
            2'd0:    apb_PRDATA = {busy, 6'd0, bus_sel, 1'b0, dev, wr_data, reg_addr};
            2'd1:    apb_PRDATA = {29'd0, done, nack, busy};
            2'd2:    apb_PRDATA = {16'd0, div};
            default: apb_PRDATA = 32'd0;
        endcase
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            sync_a <= 2'b11;
            sync_b <= 2'b11;
        end else begin
            sync_a <= {sync_a[0], plla_sda_in};
            sync_b <= {sync_b[0], pllb_sda_in};
        end
    end

    // Line drive levels are set on entry to each quarter, so they change exactly with the state
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state     <= IDLE;
            q         <= 2'd0;
            bit_idx   <= 3'd7;
            byte_idx  <= 2'd0;
            reg_addr  <= 8'd0;
            wr_data   <= 8'd0;
            dev       <= 7'd0;
            bus_sel   <= 1'b0;
            div       <= DIV_RESET;
            cnt       <= 16'd0;
            nack      <= 1'b0;
            done      <= 1'b0;
            ack_level <= 1'b1;
            busy      <= 1'b0;
            scl_low   <= 1'b0;
            sda_low   <= 1'b0;
        end else begin
            if (wr_div)
                div <= apb_PWDATA[15:0];
            if (state == IDLE) begin
                if (go) begin
                    reg_addr <= apb_PWDATA[7:0];
                    wr_data  <= apb_PWDATA[15:8];
                    dev      <= apb_PWDATA[22:16];
                    bus_sel  <= apb_PWDATA[24];
                    nack     <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b1;
                    state    <= START;
                    q        <= 2'd0;
                    byte_idx <= 2'd0;
                    bit_idx  <= 3'd7;
                    cnt      <= div;
                    scl_low  <= 1'b0;
                    sda_low  <= 1'b0;
                end
            end else if (!tick) begin
                cnt <= cnt - 16'd1;
            end else begin
                cnt <= div;
                q   <= q + 2'd1;
                case (state)
                    START: begin
                        if (q == 2'd0) begin
                            sda_low <= 1'b1;
                        end else begin
                            state   <= BIT;
                            q       <= 2'd0;
                            scl_low <= 1'b1;
                            sda_low <= ~cur_byte[7];
                        end
                    end
                    BIT: begin
                        case (q)
                            2'd1: scl_low <= 1'b0;
                            2'd3: begin
                                scl_low <= 1'b1;
                                if (bit_idx == 3'd0) begin
                                    state   <= ACK;
                                    sda_low <= 1'b0;
                                end else begin
                                    bit_idx <= bit_idx - 3'd1;
                                    sda_low <= ~cur_byte[bit_idx - 3'd1];
                                end
                            end
                            default: ;
                        endcase
                    end
                    ACK: begin
                        case (q)
                            2'd1: scl_low <= 1'b0;
                            2'd2: ack_level <= sda_sel;
                            2'd3: begin
                                scl_low <= 1'b1;
                                if (ack_level || byte_idx == 2'd2) begin
                                    state   <= STOP;
                                    sda_low <= 1'b1;
                                    nack    <= ack_level;
                                end else begin
                                    state    <= BIT;
                                    byte_idx <= byte_idx + 2'd1;
                                    bit_idx  <= 3'd7;
                                    sda_low  <= ~nxt_byte[7];
                                end
                            end
                            default: ;
                        endcase
                    end
                    STOP: begin
                        case (q)
                            2'd0: scl_low <= 1'b0;
                            2'd1: sda_low <= 1'b0;
                            2'd3: begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_i2c_master.sv
// Self-checking bench for pll_i2c_master: random I2C write commands against a
// transaction-level model, with a bus monitor/slave feeding a scoreboard.
module tb_pll_i2c_master;

    logic        clk_cpu = 1'b0;
    logic        reset;
    logic [3:0]  apb_PADDR;
    logic        apb_PSEL;
    logic        apb_PENABLE;
    logic        apb_PREADY;
    logic        apb_PWRITE;
    logic [31:0] apb_PWDATA;
    logic [31:0] apb_PRDATA;
    logic        plla_scl_oe;
    logic        plla_sda_oe;
    logic        plla_sda_in = 1'b1;
    logic        pllb_scl_oe;
    logic        pllb_sda_oe;
    logic        pllb_sda_in = 1'b1;
    logic        busy;

    pll_i2c_master dut (
        .clk_cpu     (clk_cpu),
        .reset       (reset),
        .apb_PADDR   (apb_PADDR),
        .apb_PSEL    (apb_PSEL),
        .apb_PENABLE (apb_PENABLE),
        .apb_PREADY  (apb_PREADY),
        .apb_PWRITE  (apb_PWRITE),
        .apb_PWDATA  (apb_PWDATA),
        .apb_PRDATA  (apb_PRDATA),
        .plla_scl_oe (plla_scl_oe),
        .plla_sda_oe (plla_sda_oe),
        .plla_sda_in (plla_sda_in),
        .pllb_scl_oe (pllb_scl_oe),
        .pllb_sda_oe (pllb_sda_oe),
        .pllb_sda_in (pllb_sda_in),
        .busy        (busy)
    );

    always #5 clk_cpu = ~clk_cpu;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // expected traffic, filled by stimulus and drained by the monitor
    logic [7:0] exp_bytes[$];
    int         exp_dur[$];

    logic cur_bus = 1'b0;
    int   nack_at = 3;
    int   model_div = 213;

    // monitor state
    int         run_len = 0;
    logic       busy_prev = 1'b0;
    logic       bad_other = 1'b0;
    logic       bad_timing = 1'b0;
    int         bit_cnt = 0;
    int         byte_cnt = 0;
    logic [7:0] shreg = 8'd0;
    int         last_rise = 0;
    logic       rise_valid = 1'b0;
    logic       prev_scl = 1'b1;
    logic       scl_line;
    logic       sda_line;

    always @(posedge clk_cpu) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Bus monitor and model slave: collects bytes on the selected bus, acks or
    // refuses byte nack_at, and checks transaction length and SCL timing.
    always @(negedge clk_cpu) begin
        scl_line = cur_bus ? ~pllb_scl_oe : ~plla_scl_oe;
        sda_line = cur_bus ? ~pllb_sda_oe : ~plla_sda_oe;
        if (cur_bus ? (plla_scl_oe | plla_sda_oe) : (pllb_scl_oe | pllb_sda_oe))
            bad_other = 1'b1;

        if (reset) begin
            run_len    = 0;
            busy_prev  = 1'b0;
            bad_other  = 1'b0;
            bad_timing = 1'b0;
        end else begin
            if (busy) begin
                run_len++;
            end else if (busy_prev) begin
                if (exp_dur.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL txn_end: got unexpected end after %0d cycles, expected none", run_len);
                end else begin
                    check_output("busy_cycles", 32'(run_len), 32'(exp_dur.pop_front()));
                end
                check_output("other_bus_oe", 32'(bad_other), 32'd0);
                check_output("scl_timing", 32'(bad_timing), 32'd0);
                run_len    = 0;
                bad_other  = 1'b0;
                bad_timing = 1'b0;
            end
            busy_prev = busy;
        end

        if (reset || !busy) begin
            bit_cnt     = 0;
            byte_cnt    = 0;
            shreg       = 8'd0;
            rise_valid  = 1'b0;
            prev_scl    = 1'b1;
            plla_sda_in = 1'b1;
            pllb_sda_in = 1'b1;
        end else begin
            if (scl_line && !prev_scl) begin
                if (bit_cnt >= 1 && bit_cnt <= 8 && (cyc - last_rise) != 4 * (model_div + 1))
                    bad_timing = 1'b1;
                last_rise  = cyc;
                rise_valid = 1'b1;
                if (bit_cnt < 8) begin
                    shreg = {shreg[6:0], sda_line};
                    bit_cnt++;
                    if (bit_cnt == 8) begin
                        if (exp_bytes.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL bus_byte: got unexpected 0x%02h, expected no byte", shreg);
                        end else begin
                            check_output("bus_byte", 32'(shreg), 32'(exp_bytes.pop_front()));
                        end
                    end
                end else begin
                    bit_cnt = 0;
                    byte_cnt++;
                end
            end
            if (!scl_line && prev_scl) begin
                if (rise_valid && (cyc - last_rise) != 2 * (model_div + 1))
                    bad_timing = 1'b1;
                if (cur_bus) begin
                    pllb_sda_in = (bit_cnt == 8) ? (byte_cnt == nack_at) : 1'b1;
                    plla_sda_in = 1'b1;
                end else begin
                    plla_sda_in = (bit_cnt == 8) ? (byte_cnt == nack_at) : 1'b1;
                    pllb_sda_in = 1'b1;
                end
            end
            prev_scl = scl_line;
        end
    end

    task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
        @(posedge clk_cpu); #1;
        apb_PSEL = 1'b1; apb_PWRITE = 1'b1; apb_PADDR = addr; apb_PWDATA = data; apb_PENABLE = 1'b0;
        @(posedge clk_cpu); #1;
        apb_PENABLE = 1'b1;
        @(posedge clk_cpu); #1;
        apb_PSEL = 1'b0; apb_PENABLE = 1'b0; apb_PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] addr, output logic [31:0] data);
        @(posedge clk_cpu); #1;
        apb_PSEL = 1'b1; apb_PWRITE = 1'b0; apb_PADDR = addr; apb_PENABLE = 1'b0;
        @(posedge clk_cpu); #1;
        apb_PENABLE = 1'b1;
        #1 data = apb_PRDATA;
        @(posedge clk_cpu); #1;
        apb_PSEL = 1'b0; apb_PENABLE = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [3:0] addr, input logic [31:0] expected);
        logic [31:0] rd;
        apb_read(addr, rd);
        check_output(name, rd, expected);
    endtask

    task automatic set_div(input int value);
        apb_write(4'h8, 32'(value));
        model_div = value;
    endtask

    // Model: the bytes a slave should see are {dev,W}, reg, data, cut off after
    // the refused byte; each byte is 36 quarters, plus 2 for START and 4 for STOP.
    task automatic apply_stimulus(input logic bus, input logic [6:0] dev, input logic [7:0] ra,
                                  input logic [7:0] data, input int nack_pos, input bit abort);
        logic [7:0] b[3];
        int n;
        b[0] = {dev, 1'b0};
        b[1] = ra;
        b[2] = data;
        n = (nack_pos < 3) ? nack_pos + 1 : 3;
        cur_bus = bus;
        nack_at = nack_pos;
        if (abort) begin
            exp_bytes.push_back(b[0]);
        end else begin
            for (int i = 0; i < n; i++) exp_bytes.push_back(b[i]);
            exp_dur.push_back((2 + 36 * n + 4) * (model_div + 1));
        end
        apb_write(4'h0, {1'b1, 6'd0, bus, 1'b0, dev, data, ra});
        check_output("busy_after_go", 32'(busy), 32'd1);
    endtask

    task automatic finish_txn(input logic bus, input logic [6:0] dev, input logic [7:0] ra,
                              input logic [7:0] data, input int nack_pos);
        int n = 0;
        int limit = 120 * (model_div + 1) + 100;
        while (busy && n < limit) begin
            @(posedge clk_cpu); #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL busy_timeout: got busy after %0d cycles, expected idle", n);
        end
        repeat (3) @(posedge clk_cpu);
        #1;
        check_output("bytes_left", 32'(exp_bytes.size()), 32'd0);
        check_output("txn_left", 32'(exp_dur.size()), 32'd0);
        check_reg("status", 4'h4, (nack_pos < 3) ? 32'h6 : 32'h4);
        check_reg("cmd_readback", 4'h0, {1'b0, 6'd0, bus, 1'b0, dev, data, ra});
    endtask

    initial begin : stim
        logic [31:0] rd;
        logic        bus;
        logic [6:0]  dev;
        logic [7:0]  ra;
        logic [7:0]  data;
        int          np;

        reset = 1'b1;
        apb_PADDR = 4'h0; apb_PSEL = 1'b0; apb_PENABLE = 1'b0; apb_PWRITE = 1'b0; apb_PWDATA = 32'd0;
        repeat (3) @(posedge clk_cpu);
        #1 reset = 1'b0;

        // reset state
        check_output("reset_oe", {28'd0, plla_scl_oe, plla_sda_oe, pllb_scl_oe, pllb_sda_oe}, 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("pready", 32'(apb_PREADY), 32'd1);
        check_reg("reset_div", 4'h8, 32'd213);
        check_reg("reset_status", 4'h4, 32'd0);
        check_reg("unmapped", 4'hC, 32'd0);

        // directed: bus A, all acked, fastest divider
        set_div(0);
        check_reg("div_readback", 4'h8, 32'd0);
        apply_stimulus(1'b0, 7'h60, 8'hB1, 8'h10, 3, 1'b0);
        finish_txn(1'b0, 7'h60, 8'hB1, 8'h10, 3);

        // directed: bus B, device address refused
        apply_stimulus(1'b1, 7'h60, 8'hB1, 8'h10, 0, 1'b0);
        finish_txn(1'b1, 7'h60, 8'hB1, 8'h10, 0);

        // go and DIV write while busy are ignored
        set_div(2);
        apply_stimulus(1'b0, 7'h2A, 8'h5C, 8'hE7, 3, 1'b0);
        apb_write(4'h0, 32'h8155_AA33);
        apb_write(4'h8, 32'd50);
        check_reg("div_while_busy", 4'h8, 32'd2);
        check_reg("cmd_while_busy", 4'h0, {1'b1, 6'd0, 1'b0, 1'b0, 7'h2A, 8'hE7, 8'h5C});
        check_reg("status_while_busy", 4'h4, 32'h1);
        finish_txn(1'b0, 7'h2A, 8'h5C, 8'hE7, 3);

        // random commands
        for (int t = 0; t < 6; t++) begin
            set_div(int'($urandom_range(0, 3)));
            bus  = 1'($urandom_range(0, 1));
            dev  = 7'($urandom);
            ra   = 8'($urandom);
            data = 8'($urandom);
            np   = int'($urandom_range(0, 5));
            if (np > 3) np = 3;
            apply_stimulus(bus, dev, ra, data, np, 1'b0);
            finish_txn(bus, dev, ra, data, np);
        end

        // reset in the middle of byte1
        set_div(1);
        apply_stimulus(1'b0, 7'h5A, 8'h3C, 8'hC3, 3, 1'b1);
        repeat (100) @(posedge clk_cpu);
        #1 reset = 1'b1;
        @(posedge clk_cpu);
        #1;
        check_output("abort_oe", {28'd0, plla_scl_oe, plla_sda_oe, pllb_scl_oe, pllb_sda_oe}, 32'd0);
        check_output("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        model_div = 213;
        check_reg("abort_status", 4'h4, 32'd0);
        check_reg("abort_div", 4'h8, 32'd213);
        check_output("abort_bytes_left", 32'(exp_bytes.size()), 32'd0);
        set_div(0);
        apply_stimulus(1'b1, 7'h11, 8'h22, 8'h33, 3, 1'b0);
        finish_txn(1'b1, 7'h11, 8'h22, 8'h33, 3);

        // default divider: SCL high 2*214 cycles, bit period 856 cycles
        set_div(213);
        apply_stimulus(1'b0, 7'h69, 8'h0F, 8'hA5, 3, 1'b0);
        finish_txn(1'b0, 7'h69, 8'h0F, 8'hA5, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #800_000;
        $display("[TB] FAIL watchdog: got no finish by %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
